sram_master_ar_aw: RTL

SRAM_MASTER_AR_AW -- requirements
Module: sram_master_ar_aw

---
 rtl/sram_if_pkg.sv | 22 ++
 rtl/phase_cnt.sv | 31 +++
 rtl/sram_master_ar_aw.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/sram_if_pkg.sv
// Shared definitions for the asynchronous SRAM master: FSM state encoding and
// the helper that sizes the single phase down-counter.
package sram_if_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Counter width able to hold the longest phase length.
  function automatic int phase_cnt_width(input int setup_cyc, input int wait_cyc,
                                         input int hold_cyc);
    int longest;
    longest = setup_cyc;
    if (wait_cyc > longest) longest = wait_cyc;
    if (hold_cyc > longest) longest = hold_cyc;
    return $clog2(longest) + 1;
  endfunction

endpackage

// File: rtl/phase_cnt.sv
// Phase timer: loadable down-counter with a zero flag. It stops at zero, and a
// load takes priority over a decrement.
module phase_cnt #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count;

  // Load a new phase length, or count down toward zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - ONE;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/sram_master_ar_aw.sv
// Host-to-asynchronous-SRAM master. Each request runs through SETUP, ACCESS and
// HOLD phases with registered SRAM controls, then returns to IDLE for a cycle.
module sram_master_ar_aw
  import sram_if_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int SETUP_CYC  = 1,
  parameter int WAIT_CYC   = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [ADDR_WIDTH-1:0] address,
  inout  wire  [DATA_WIDTH-1:0] data,
  output logic                  cs,
  output logic                  we,
  output logic                  oe
);

  localparam int CW = phase_cnt_width(SETUP_CYC, WAIT_CYC, HOLD_CYC);
  localparam logic [CW-1:0] SETUP_LD = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] WAIT_LD  = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYC - 1);

  state_t                state;
  state_t                next_state;
  logic                  accept;
  logic                  cnt_load;
  logic                  cnt_dec;
  logic [CW-1:0]         cnt_val;
  logic                  cnt_zero;
  logic                  cap_we;
  logic                  write_sel;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  drive_en;
  logic                  cs_d;
  logic                  we_d;
  logic                  oe_d;
  logic                  drive_d;
  logic                  read_done;

  phase_cnt #(.WIDTH(CW)) u_phase_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (cnt_load),
    .load_val (cnt_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  assign req_ready = (state == ST_IDLE);

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and phase-timer control; each phase loads its length minus one.
  always_comb begin
    next_state = state;
    accept     = 1'b0;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_val    = '0;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          next_state = ST_SETUP;
          cnt_load   = 1'b1;
          cnt_val    = SETUP_LD;
        end
      end
      ST_SETUP: begin
        if (cnt_zero) begin
          next_state = ST_ACCESS;
          cnt_load   = 1'b1;
          cnt_val    = WAIT_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_ACCESS: begin
        if (cnt_zero) begin
          next_state = ST_HOLD;
          cnt_load   = 1'b1;
          cnt_val    = HOLD_LD;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_zero) begin
          next_state = ST_IDLE;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Next-cycle SRAM controls derived from the next state, so the registered
  // outputs line up with the state they belong to.
  always_comb begin
    write_sel = accept ? req_we : cap_we;
    cs_d      = (next_state != ST_IDLE);
    we_d      = (next_state == ST_ACCESS) && write_sel;
    oe_d      = (next_state == ST_ACCESS) && !write_sel;
    drive_d   = cs_d && write_sel;
    read_done = (state == ST_ACCESS) && cnt_zero && !cap_we;
  end

  // Capture the request at acceptance; address holds its value while idle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cap_we  <= 1'b0;
      wdata_q <= '0;
      address <= '0;
    end else if (accept) begin
      cap_we  <= req_we;
      wdata_q <= req_wdata;
      address <= req_addr;
    end
  end

  // Registered SRAM strobes and data-drive enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs       <= 1'b0;
      we       <= 1'b0;
      oe       <= 1'b0;
      drive_en <= 1'b0;
    end else begin
      cs       <= cs_d;
      we       <= we_d;
      oe       <= oe_d;
      drive_en <= drive_d;
    end
  end

  // Read data is sampled as the last ACCESS cycle ends; the pulse lands in HOLD.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      rsp_valid <= read_done;
      if (read_done) begin
        rsp_rdata <= data;
      end
    end
  end

  assign data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule
